// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready request sequencer that drives the ram_basic single-port RAM strobes.
// Optional feature macro RAM_CTRL_INIT_EN: zero-fill the whole RAM after reset before serving requests.
module ram_ctrl #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              ram_CS,
    output logic              ram_WR,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              ram_en
);

    localparam int unsigned MAX_CYC = (HOLD_CYC > RD_LAT) ? HOLD_CYC : RD_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
`ifdef RAM_CTRL_INIT_EN
        , S_INIT
`endif
    } state_t;

`ifdef RAM_CTRL_INIT_EN
    localparam state_t S_RST = S_INIT;
`else
    localparam state_t S_RST = S_IDLE;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_req_ready;
    logic                w_ready_nxt;
    logic                r_rsp_valid;
    logic                w_rsp_vld_nxt;
    logic                r_rsp_wr;
    logic                w_rsp_wr_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                r_cs;
    logic                w_cs_nxt;
    logic                r_wr;
    logic                w_wr_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                r_en;
    logic                w_accept;

`ifdef RAM_CTRL_INIT_EN
    logic [ADDR_W:0]     r_init_addr;
    logic [ADDR_W:0]     w_init_addr_nxt;
    logic                r_init_done;
    logic                w_init_done_nxt;
    localparam logic [ADDR_W:0] INIT_ONE = (ADDR_W + 1)'(1);
`endif

    // r_req_ready is only ever set on the way into IDLE/RESP, so it doubles as the accept window
    assign w_accept = req_valid && r_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RST;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= '0;
            r_cs        <= 1'b1;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_en        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_ready_nxt;
            r_rsp_valid <= w_rsp_vld_nxt;
            r_rsp_wr    <= w_rsp_wr_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            r_cs        <= w_cs_nxt;
            r_wr        <= w_wr_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_en        <= 1'b1;
        end
    end

`ifdef RAM_CTRL_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_addr <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_addr <= w_init_addr_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = r_req_ready;
        w_rsp_vld_nxt = 1'b0;
        w_rsp_wr_nxt  = r_rsp_wr;
        w_rdata_nxt   = r_rsp_rdata;
        w_cs_nxt      = r_cs;
        w_wr_nxt      = r_wr;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
`ifdef RAM_CTRL_INIT_EN
        w_init_addr_nxt = r_init_addr;
        w_init_done_nxt = r_init_done;
`endif
        case (r_state)
            S_IDLE, S_RESP: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = HOLD_LD;
                    w_ready_nxt = 1'b0;
                    w_cs_nxt    = 1'b0;
                    w_wr_nxt    = req_wr;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                end
            end
            S_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_cs_nxt = 1'b1;
`ifdef RAM_CTRL_INIT_EN
                    if (!r_init_done) begin
                        w_state_nxt     = S_INIT;
                        w_init_addr_nxt = r_init_addr + INIT_ONE;
                    end else
`endif
                    if (r_wr) begin
                        w_state_nxt   = S_RESP;
                        w_ready_nxt   = 1'b1;
                        w_rsp_vld_nxt = 1'b1;
                        w_rsp_wr_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = LAT_LD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_rdata_nxt   = ram_data_out;
                    w_state_nxt   = S_RESP;
                    w_ready_nxt   = 1'b1;
                    w_rsp_vld_nxt = 1'b1;
                    w_rsp_wr_nxt  = 1'b0;
                end
            end
`ifdef RAM_CTRL_INIT_EN
            S_INIT: begin
                // INIT is revisited between fill writes, giving the one-cycle CS-high gap
                if (r_init_addr[ADDR_W]) begin
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_ready_nxt     = 1'b1;
                end else begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = HOLD_LD;
                    w_cs_nxt    = 1'b0;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = r_init_addr[ADDR_W-1:0];
                    w_wdata_nxt = '0;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_wr      = r_rsp_wr;
    assign rsp_rdata   = r_rsp_rdata;
    assign ram_CS      = r_cs;
    assign ram_WR      = r_wr;
    assign ram_addr    = r_addr;
    assign ram_data_in = r_wdata;
    assign ram_en      = r_en;

`ifdef RAM_CTRL_INIT_EN
    assign init_done = r_init_done;
`else
    assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: a behavioural RAM, a transaction-timeline reference model,
// directed scenarios with literal expectations, and randomized request traffic.
module tb_ram_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int H     = 2;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;
`ifdef RAM_CTRL_INIT_EN
    localparam int OP_CYC = DEPTH * (H + 1) + 1;
`else
    localparam int OP_CYC = 1;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wr    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_wr, init_done, ram_CS, ram_WR, ram_en;
    logic [DW-1:0] rsp_rdata, ram_data_in;
    logic [DW-1:0] ram_data_out = '0;
    logic [AW-1:0] ram_addr;

    int   n_vec    = 0;
    int   n_err    = 0;
    int   tcyc     = 0;
    int   cs_falls = 0;
    logic cs_prev  = 1'b1;

    ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYC(H), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ram_CS(ram_CS), .ram_WR(ram_WR), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_en(ram_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    // Behavioural RAM: one-cycle read latency after the access ends
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i * 37 + 11);
            ref_mem[i] = DW'(i * 37 + 11);
        end
    end
    always @(posedge clk) begin
        if (!ram_CS && ram_WR) mem[ram_addr] <= ram_data_in;
        if (!ram_CS && !ram_WR && ram_en) ram_data_out <= mem[ram_addr];
    end

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void timeout(string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
    endfunction

    // Reference model: cyc = edges since reset release; a request accepted at edge k owns
    // CS-low cycles [k, k+H) and responds in cycle k+H (write) or k+H+RL (read).
    int            cyc = 0, k = 0, done = 0;
    bit            pend = 1'b0, p_wr = 1'b0;
    logic [DW-1:0] p_rd = '0, e_rdata = '0, e_wdata = '0;
    logic          e_rsp_wr = 1'b0, e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;

    function automatic bit exp_ready(int c);
        return (c >= OP_CYC) && !(pend && c >= k && c < done);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; pend = 1'b0; e_rsp_wr = 1'b0; e_rdata = '0;
            e_wr = 1'b0; e_addr = '0; e_wdata = '0;
        end else begin
            if (req_valid && exp_ready(cyc)) begin
                pend = 1'b1; k = cyc + 1; p_wr = req_wr;
                done = k + H + (req_wr ? 0 : RL);
                e_wr = req_wr; e_addr = req_addr; e_wdata = req_wdata;
                if (req_wr) ref_mem[req_addr] = req_wdata;
                else        p_rd = ref_mem[req_addr];
            end
            cyc = cyc + 1;
`ifdef RAM_CTRL_INIT_EN
            if (cyc == OP_CYC) begin
                e_wr = 1'b1; e_addr = '1; e_wdata = '0;
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end
`endif
            if (pend && cyc == done) begin
                e_rsp_wr = p_wr;
                if (!p_wr) e_rdata = p_rd;
            end
        end
    end

    always @(negedge clk) begin
        bit cs_lo;
        cs_lo = pend && cyc >= k && cyc < k + H;
        if (cs_prev && !ram_CS) cs_falls++;
        cs_prev = ram_CS;
        chk("req_ready", int'(req_ready), int'(exp_ready(cyc)));
        chk("rsp_valid", int'(rsp_valid), int'(pend && cyc == done));
        chk("rsp_wr",    int'(rsp_wr),    int'(e_rsp_wr));
        chk("rsp_rdata", int'(rsp_rdata), int'(e_rdata));
        chk("ram_en",    int'(ram_en),    int'(cyc >= 1));
`ifdef RAM_CTRL_INIT_EN
        chk("init_done", int'(init_done), int'(cyc >= OP_CYC));
`else
        chk("init_done", int'(init_done), 1);
`endif
        if (cyc == 0 || cyc >= OP_CYC) begin
            chk("ram_CS",      int'(ram_CS),      int'(!cs_lo));
            chk("ram_WR",      int'(ram_WR),      int'(e_wr));
            chk("ram_addr",    int'(ram_addr),    int'(e_addr));
            chk("ram_data_in", int'(ram_data_in), int'(e_wdata));
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic wait_ready(output int waited);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) timeout("req_ready");
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_t, output int waited);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        wait_ready(waited);
        @(posedge clk); #1;
        acc_t = tcyc;
        req_valid = 1'b0;
    endtask

    task automatic observe(input int ncyc, input logic [AW-1:0] a, output int lows, output int bad,
                           output int rsp_t, output logic [DW-1:0] rd, output logic rwr);
        lows = 0; bad = 0; rsp_t = -1; rd = '0; rwr = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!ram_CS) begin
                lows++;
                if (ram_addr != a) bad++;
            end
            if (rsp_valid && rsp_t < 0) begin
                rsp_t = tcyc; rd = rsp_rdata; rwr = rsp_wr;
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef RAM_CTRL_INIT_EN
    task automatic wait_init();
        int t0 = tcyc;
        int n  = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!init_done) timeout("init_done");
        else chk("init_done_cycles", tcyc - t0, 193);  // 64 fills x 3 cycles, +1 to leave INIT
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w, lows, bad, rt, f0, nrd;
        logic [DW-1:0] rd;
        logic rwr, prev_wr;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_CS", int'(ram_CS), 1);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_ram_en", int'(ram_en), 0);
        #2 rst_n = 1'b1;
`ifdef RAM_CTRL_INIT_EN
        wait_init();
        send(1'b0, 6'h1F, 8'h00, t, w);
        observe(4, 6'h1F, lows, bad, rt, rd, rwr);
        chk("init_rd_1F", int'(rd), 8'h00);
`else
        @(posedge clk); #1;
`endif

        // Write 0x00/0xAA, read it back
        send(1'b1, 6'h00, 8'hAA, t, w);
        observe(3, 6'h00, lows, bad, rt, rd, rwr);
        chk("wr_lat", rt - t, 2);
        chk("wr_rsp_wr", int'(rwr), 1);
        chk("wr_cs_low", lows, 2);
        send(1'b0, 6'h00, 8'h00, t, w);
        observe(4, 6'h00, lows, bad, rt, rd, rwr);
        chk("rd_lat", rt - t, 3);
        chk("rd_data_AA", int'(rd), 8'hAA);
        chk("rd_rsp_wr", int'(rwr), 0);
        chk("rd_cs_low", lows, 2);

        // Top address
        send(1'b1, 6'h3F, 8'hFF, t, w);
        observe(3, 6'h3F, lows, bad, rt, rd, rwr);
        chk("wr3F_cs_low", lows, 2);
        chk("wr3F_addr_stable", bad, 0);
        send(1'b0, 6'h3F, 8'h00, t, w);
        observe(4, 6'h3F, lows, bad, rt, rd, rwr);
        chk("rd3F_cs_low", lows, 2);
        chk("rd3F_addr_stable", bad, 0);
        chk("rd3F_data", int'(rd), 8'hFF);

        // Back-to-back alternating write/read at 0x05, valid held high throughout
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 6'h05; req_wdata = 8'h5A;
        prev_wr = 1'b1; f0 = 0; nrd = 0;
        for (int s = 0; s < 6; s++) begin
            wait_ready(w);
            if (s > 0 && rsp_valid && !rsp_wr) begin
                chk("b2b_rdata", int'(rsp_rdata), 8'h5A);
                nrd++;
            end
            @(posedge clk); #1;
            if (s > 0) chk("b2b_gap", tcyc - f0, prev_wr ? 3 : 4);
            f0 = tcyc;
            prev_wr = req_wr;
            req_wr = ~req_wr;
        end
        req_valid = 1'b0;
        observe(4, 6'h05, lows, bad, rt, rd, rwr);
        chk("b2b_last_rd", int'(rd), 8'h5A);
        chk("b2b_reads_seen", nrd, 2);

        // Request held during a write's ACCESS: waits for ready, one access per handshake
        f0 = cs_falls;
        send(1'b1, 6'h10, 8'h33, t, w);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 6'h10;
        wait_ready(w);
        chk("hold_wait_cycles", w, 2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        observe(4, 6'h10, lows, bad, rt, rd, rwr);
        chk("hold_rd_data", int'(rd), 8'h33);
        chk("hold_cs_falls", cs_falls - f0, 2);

        // Reset in the cycle after a read accept
        send(1'b0, 6'h3F, 8'h00, t, w);
        rst_n = 1'b0;
        #1;
        chk("midrst_ram_CS", int'(ram_CS), 1);
        chk("midrst_req_ready", int'(req_ready), 0);
        rt = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rt++;
        end
        chk("midrst_no_rsp", rt, 0);
        #2 rst_n = 1'b1;
`ifdef RAM_CTRL_INIT_EN
        wait_init();
`else
        @(posedge clk); #1;
`endif
        send(1'b0, 6'h3F, 8'h00, t, w);
        observe(4, 6'h3F, lows, bad, rt, rd, rwr);
`ifdef RAM_CTRL_INIT_EN
        chk("postrst_rd3F", int'(rd), 8'h00);
`else
        chk("postrst_rd3F", int'(rd), 8'hFF);
`endif

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 300; i++) begin
            logic          wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            wr = ($urandom & 1) != 0;
            a  = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7));
            d  = DW'($urandom);
            send(wr, a, d, t, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (8) begin
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Request-driven access sequencer sitting directly upstream of `ram_basic`, the 64x8 single-port RAM. It accepts single-beat read/write requests on a valid/ready handshake and generates the RAM's `CS`/`WR`/`addr`/`data_in`/`en` strobes with correct setup and hold. It captures `data_out` after the RAM's read latency and returns it on a one-cycle response strobe. It replaces hand-driven task stimulus with a synthesizable, cycle-exact master.

## Interface
- `ADDR_W`, 6: RAM address width; depth = 2**ADDR_W.
- `DATA_W`, 8: data width.
- `HOLD_CYC`, 2: cycles `CS` is held low per access; must be ≥1.
- `RD_LAT`, 1: cycles from end of read access to valid `data_out`; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_wr`  out  1  type of the completed request.
- `rsp_rdata`  out  DATA_W  read data; valid when `rsp_valid && !rsp_wr`.
- `init_done`  out  1  controller operational.
- `ram_CS`  out  1  RAM chip select, active low.
- `ram_WR`  out  1  1 = write, 0 = read.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_data_in`  out  DATA_W  RAM write data.
- `ram_data_out`  in  DATA_W  RAM read data.
- `ram_en`  out  1  RAM output enable.

## Operation
**States:** INIT (macro only), IDLE, ACCESS, WAIT, RESP.

**Reset values:**
- `req_ready`=0, `rsp_valid`=0, `rsp_wr`=0, `rsp_rdata`=0.
- `ram_CS`=1, `ram_WR`=0, `ram_addr`=0, `ram_data_in`=0, `ram_en`=0.
- `init_done`: 0 with the macro, 1 without.

**State behaviour:**
- **IDLE:** `req_ready`=1 and `ram_CS`=1. On `req_valid && req_ready`, latch `req_wr`, `req_addr` and `req_wdata` into the `ram_*` registers, drive `ram_CS`=0, and go to ACCESS.
- **ACCESS:**
  - `ram_CS`=0 and `ram_WR`, `ram_addr`, `ram_data_in` stable for exactly HOLD_CYC cycles; a down-counter tracks the cycles.
  - On expiry, `ram_CS`=1.
  - Write: go to RESP.
  - Read: go to WAIT.
- **WAIT:** RD_LAT cycles with `ram_CS`=1, then sample `ram_data_out` into `rsp_rdata` and go to RESP.
- **RESP:**
  - One cycle: `rsp_valid`=1, `rsp_wr`=latched type, `req_ready`=1.
  - A request accepted in RESP behaves exactly as one accepted in IDLE.
  - Next state is ACCESS if a request was accepted, otherwise IDLE.

**Other rules:**
- `ram_en`=1 from the first clock after reset release onward.
- `req_ready`=0 in ACCESS, WAIT and INIT.
- Any `req_valid` while `req_ready`=0 is ignored and not queued; the requester holds it.
- `rsp_rdata` holds its value until the next read completes; writes do not alter it.
- No back-pressure on responses: `rsp_valid` is never stretched.
- `ram_WR`, `ram_addr` and `ram_data_in` keep their last values while `ram_CS`=1.
- Address arithmetic: the INIT counter is ADDR_W+1 bits; only the low ADDR_W bits drive `ram_addr`.

## Timing
Request accepted at edge k:
- `ram_CS` falls after edge k and rises after edge k+HOLD_CYC.
- Write: `rsp_valid` high in the cycle after edge k+HOLD_CYC. Busy period (`req_ready`=0) = HOLD_CYC cycles.
- Read: `rsp_valid` and `rsp_rdata` valid in the cycle after edge k+HOLD_CYC+RD_LAT. Busy period = HOLD_CYC+RD_LAT cycles.
- Back-to-back requests accepted in RESP give gapless throughput: one access per HOLD_CYC+1 cycles (writes) or HOLD_CYC+RD_LAT+1 cycles (reads).
- Reset mid-operation: all outputs return to their reset values asynchronously (`ram_CS`=1 immediately). The in-flight request is dropped with no `rsp_valid`.

## Configuration
- `RAM_CTRL_INIT_EN` defined:
  - After reset, enter INIT and write 0 to addresses 0 through 2**ADDR_W−1 in ascending order.
  - Each write uses the ACCESS timing, with `ram_CS` high for one cycle between writes.
  - No `rsp_valid` is generated during INIT.
  - After the last address, `init_done` rises and the state goes to IDLE.
  - `init_done` stays 1 until the next reset.
  - A reset during INIT restarts INIT at address 0.
- `RAM_CTRL_INIT_EN` undefined: no INIT state; reset goes straight to IDLE; `init_done` is constant 1.

## Test plan
- Write addr 0x00, data 0xAA, then read addr 0x00 -> `rsp_valid` pulses with `rsp_wr`=1, then `rsp_rdata`=0xAA with `rsp_wr`=0; read completes 3 cycles after accept (defaults).
- Write 0x3F/0xFF, then read 0x3F -> `rsp_rdata`=0xFF; `ram_CS` low exactly 2 cycles per access; `ram_addr`=0x3F stable throughout.
- With `RAM_CTRL_INIT_EN`: release reset, wait for `init_done`, read 0x1F -> 0x00. Check `init_done` rises after 64 writes × 3 cycles.
- Hold `req_valid` continuously with alternating write/read to 0x05 (data 0x5A) -> each request accepted in the RESP cycle; no idle cycles; read returns 0x5A.
- Assert `rst_n`=0 in the cycle after a read accept -> `ram_CS`=1 immediately; no `rsp_valid`; after release the first read of a previously written address returns the correct data.
- Hold `req_valid` during the ACCESS of a prior write -> the request is not accepted until `req_ready`=1; exactly one access per handshake.
